// File: rtl/smart_ram_pkg.sv
// rtl/smart_ram_pkg.sv - shared constants and FSM encoding for the smart_ram responder
//
// Purpose: state encoding for the SRAM access FSM, default wait states and the
//          sample/offset widths shared with the effect blocks.
// Ports:   none (package)
package smart_ram_pkg;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_ADDR_WIDTH = 12;
  localparam int DEF_READ_WAIT  = 2;
  localparam int DEF_WRITE_WAIT = 2;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_RD      = 3'd1;
  localparam logic [2:0] ST_RD_DONE = 3'd2;
  localparam logic [2:0] ST_W_SETUP = 3'd3;
  localparam logic [2:0] ST_W_PULSE = 3'd4;
  localparam logic [2:0] ST_W_HOLD  = 3'd5;
  localparam logic [2:0] ST_WR_DONE = 3'd6;

  typedef enum logic [2:0] {
    S_IDLE    = ST_IDLE,
    S_RD      = ST_RD,
    S_RD_DONE = ST_RD_DONE,
    S_W_SETUP = ST_W_SETUP,
    S_W_PULSE = ST_W_PULSE,
    S_W_HOLD  = ST_W_HOLD,
    S_WR_DONE = ST_WR_DONE
  } state_e;

endpackage

// File: rtl/smart_ram_addr_gen.sv
// rtl/smart_ram_addr_gen.sv - circular-buffer head counter and physical address generator
//
// Purpose: keeps the head pointer (advanced once per audio sample) and turns an
//          offset behind the head into a physical SRAM address.
// Ports:   clk_i, rst_i      clock, synchronous active-high reset
//          sample_tick_i     advance head by one (wraps at 2^ADDR_WIDTH)
//          offset_i          offset behind head
//          addr_o            BASE_ADDR + ((head - offset) mod 2^ADDR_WIDTH), combinational
module smart_ram_addr_gen
  import smart_ram_pkg::*;
#(
  parameter int                         ADDR_WIDTH      = DEF_ADDR_WIDTH,
  parameter int                         SRAM_ADDR_WIDTH = 18,
  parameter logic [SRAM_ADDR_WIDTH-1:0] BASE_ADDR       = '0
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       sample_tick_i,
  input  logic [ADDR_WIDTH-1:0]      offset_i,
  output logic [SRAM_ADDR_WIDTH-1:0] addr_o
);

  logic [ADDR_WIDTH-1:0] head_q;
  logic [ADDR_WIDTH-1:0] head_d;
  logic [ADDR_WIDTH-1:0] rel;

  // Natural ADDR_WIDTH overflow provides both the head wrap and the modulo subtract.
  assign head_d = sample_tick_i ? head_q + 1'b1 : head_q;
  assign rel    = head_q - offset_i;
  assign addr_o = BASE_ADDR + SRAM_ADDR_WIDTH'(rel);

  always_ff @(posedge clk_i) begin
    if (rst_i) head_q <= '0;
    else       head_q <= head_d;
  end

endmodule

// File: rtl/smart_ram.sv
// rtl/smart_ram.sv - effects-to-SRAM responder driving an asynchronous 16-bit SRAM
//
// Purpose: latches read/write request pulses, serialises them onto the SRAM pins
//          with programmable wait states, returns one-cycle finish pulses.
// Ports:   clk, rst                    clock, synchronous active-high reset
//          sample_tick                 advance circular-buffer head
//          req_rd, req_wr              request pulses
//          req_offset, req_data        offset behind head, write data
//          rd_data                     last read word
//          read_finish, write_finish   completion pulses
//          busy                        FSM active or request pending
//          sram_*                      SRAM address, data, tri-state enable, strobes
module smart_ram
  import smart_ram_pkg::*;
#(
  parameter int                         DATA_WIDTH      = DEF_DATA_WIDTH,
  parameter int                         ADDR_WIDTH      = DEF_ADDR_WIDTH,
  parameter int                         SRAM_ADDR_WIDTH = 18,
  parameter logic [SRAM_ADDR_WIDTH-1:0] BASE_ADDR       = '0,
  parameter int                         READ_WAIT       = DEF_READ_WAIT,
  parameter int                         WRITE_WAIT      = DEF_WRITE_WAIT
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       sample_tick,
  input  logic                       req_rd,
  input  logic                       req_wr,
  input  logic [ADDR_WIDTH-1:0]      req_offset,
  input  logic [DATA_WIDTH-1:0]      req_data,
  output logic [DATA_WIDTH-1:0]      rd_data,
  output logic                       read_finish,
  output logic                       write_finish,
  output logic                       busy,
  output logic [SRAM_ADDR_WIDTH-1:0] sram_addr,
  output logic [DATA_WIDTH-1:0]      sram_dq_out,
  output logic                       sram_dq_oe,
  input  logic [DATA_WIDTH-1:0]      sram_dq_in,
  output logic                       sram_ce_n,
  output logic                       sram_oe_n,
  output logic                       sram_we_n,
  output logic                       sram_ub_n,
  output logic                       sram_lb_n
);

  localparam int CNT_W = 8;

  state_e                     state_q, state_d;
  logic                       pend_rd_q, pend_rd_d;
  logic                       pend_wr_q, pend_wr_d;
  logic [SRAM_ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic [SRAM_ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0]      wr_data_q, wr_data_d;
  logic [DATA_WIDTH-1:0]      rd_data_q, rd_data_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic [SRAM_ADDR_WIDTH-1:0] req_addr;

  smart_ram_addr_gen #(
    .ADDR_WIDTH      (ADDR_WIDTH),
    .SRAM_ADDR_WIDTH (SRAM_ADDR_WIDTH),
    .BASE_ADDR       (BASE_ADDR)
  ) u_addr_gen (
    .clk_i         (clk),
    .rst_i         (rst),
    .sample_tick_i (sample_tick),
    .offset_i      (req_offset),
    .addr_o        (req_addr)
  );

  // Next-state, request capture and wait counting.
  always_comb begin
    state_d   = state_q;
    pend_rd_d = pend_rd_q;
    pend_wr_d = pend_wr_q;
    rd_addr_d = rd_addr_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    rd_data_d = rd_data_q;
    cnt_d     = cnt_q;

    if (req_rd) begin
      pend_rd_d = 1'b1;
      rd_addr_d = req_addr;
    end
    if (req_wr) begin
      pend_wr_d = 1'b1;
      wr_addr_d = req_addr;
      wr_data_d = req_data;
    end

    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        // Raw request pulses bypass the pending flags so an idle launch costs no cycle.
        if (pend_rd_q || req_rd)      state_d = S_RD;
        else if (pend_wr_q || req_wr) state_d = S_W_SETUP;
      end
      S_RD: begin
        if (cnt_q == CNT_W'(READ_WAIT - 1)) begin
          rd_data_d = sram_dq_in;
          cnt_d     = '0;
          state_d   = S_RD_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RD_DONE: begin
        // A fresh read landing here must survive the clear.
        if (!req_rd) pend_rd_d = 1'b0;
        state_d = S_IDLE;
      end
      S_W_SETUP: begin
        cnt_d   = '0;
        state_d = S_W_PULSE;
      end
      S_W_PULSE: begin
        if (cnt_q == CNT_W'(WRITE_WAIT - 1)) begin
          cnt_d   = '0;
          state_d = S_W_HOLD;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_W_HOLD: state_d = S_WR_DONE;
      S_WR_DONE: begin
        if (!req_wr) pend_wr_d = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Pin drive decoded from the registered state; dq_oe is only ever high while oe_n is high.
  always_comb begin
    sram_ce_n    = 1'b1;
    sram_oe_n    = 1'b1;
    sram_we_n    = 1'b1;
    sram_dq_oe   = 1'b0;
    sram_addr    = '0;
    sram_dq_out  = '0;
    read_finish  = 1'b0;
    write_finish = 1'b0;
    unique case (state_q)
      S_RD: begin
        sram_ce_n = 1'b0;
        sram_oe_n = 1'b0;
        sram_addr = rd_addr_q;
      end
      S_RD_DONE: read_finish = 1'b1;
      S_W_SETUP, S_W_HOLD: begin
        sram_ce_n   = 1'b0;
        sram_dq_oe  = 1'b1;
        sram_addr   = wr_addr_q;
        sram_dq_out = wr_data_q;
      end
      S_W_PULSE: begin
        sram_ce_n   = 1'b0;
        sram_we_n   = 1'b0;
        sram_dq_oe  = 1'b1;
        sram_addr   = wr_addr_q;
        sram_dq_out = wr_data_q;
      end
      S_WR_DONE: write_finish = 1'b1;
      default: ;
    endcase
  end

  assign sram_ub_n = 1'b0;
  assign sram_lb_n = 1'b0;
  assign rd_data   = rd_data_q;
  assign busy      = (state_q != S_IDLE) || pend_rd_q || pend_wr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      pend_rd_q <= 1'b0;
      pend_wr_q <= 1'b0;
      rd_addr_q <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      rd_data_q <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      pend_rd_q <= pend_rd_d;
      pend_wr_q <= pend_wr_d;
      rd_addr_q <= rd_addr_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      rd_data_q <= rd_data_d;
      cnt_q     <= cnt_d;
    end
  end

endmodule

// File: tb/tb_smart_ram.sv
// tb/tb_smart_ram.sv - scoreboard bench for smart_ram against a behavioural SRAM
//
// Purpose: drives request pulses, models the SRAM, checks timing, addressing and data.
// Ports:   none (top-level bench)
module tb_smart_ram;

  localparam logic [17:0] BASE = 18'h00100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sample_tick = 1'b0;
  logic        req_rd = 1'b0;
  logic        req_wr = 1'b0;
  logic [11:0] req_offset = '0;
  logic [15:0] req_data = '0;
  logic [15:0] rd_data;
  logic        read_finish, write_finish, busy;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out, sram_dq_in;
  logic        sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n;

  smart_ram #(.BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst), .sample_tick(sample_tick),
    .req_rd(req_rd), .req_wr(req_wr), .req_offset(req_offset), .req_data(req_data),
    .rd_data(rd_data), .read_finish(read_finish), .write_finish(write_finish), .busy(busy),
    .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_oe(sram_dq_oe),
    .sram_dq_in(sram_dq_in), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
    .sram_we_n(sram_we_n), .sram_ub_n(sram_ub_n), .sram_lb_n(sram_lb_n)
  );

  always #5 clk = ~clk;

  // Behavioural SRAM: write while ce_n/we_n low, read data visible while ce_n/oe_n low.
  logic [15:0] mem [0:262143];
  logic        pre_en = 1'b0;
  logic [17:0] pre_addr = '0;
  logic [15:0] pre_data = '0;
  always @(posedge clk) begin
    if (pre_en) mem[pre_addr] <= pre_data;
    else if (!sram_ce_n && !sram_we_n && sram_dq_oe) mem[sram_addr] <= sram_dq_out;
  end
  assign sram_dq_in = (!sram_ce_n && !sram_oe_n) ? mem[sram_addr] : 16'hDEAD;

  typedef struct packed { logic [17:0] addr; logic [15:0] data; } exp_t;
  exp_t rd_q[$];
  exp_t wr_q[$];

  int tests = 0;
  int fails = 0;
  logic [11:0] model_head = '0;

  int          rf_cyc, wf_cyc, rf_cnt, wf_cnt, oe_low, we_low, contention, dq_oe_cnt, dq_changes;
  logic [17:0] oe_addr, we_addr;
  logic [15:0] rf_data, dq_first;
  logic        busy_at [0:31];

  function automatic logic [17:0] exp_addr(input logic [11:0] head, input logic [11:0] off);
    logic [11:0] rel;
    rel = head - off;
    return BASE + {6'b0, rel};
  endfunction

  task automatic preload(input logic [17:0] a, input logic [15:0] d);
    @(posedge clk); #1;
    pre_en = 1'b1; pre_addr = a; pre_data = d;
    @(posedge clk); #1;
    pre_en = 1'b0;
  endtask

  task automatic ticks(input int n);
    @(posedge clk); #1;
    sample_tick = 1'b1;
    repeat (n) @(posedge clk);
    #1 sample_tick = 1'b0;
    model_head = model_head + 12'(n);
  endtask

  // One-cycle request pulse; returns in the cycle after the sampling edge (cycle 1).
  task automatic issue(input logic rd, input logic wr, input logic [11:0] off, input logic [15:0] d);
    exp_t e;
    @(posedge clk); #1;
    req_rd = rd; req_wr = wr; req_offset = off; req_data = d;
    e.addr = exp_addr(model_head, off);
    e.data = d;
    if (wr) wr_q.push_back(e);
    if (rd) begin
      e.data = mem[e.addr];
      rd_q.push_back(e);
    end
    @(posedge clk); #1;
    req_rd = 1'b0; req_wr = 1'b0;
  endtask

  // Records what the pins do for n cycles; cycle 1 is the cycle after the request edge.
  task automatic watch(input int n);
    rf_cyc = -1; wf_cyc = -1; rf_cnt = 0; wf_cnt = 0; oe_low = 0; we_low = 0;
    contention = 0; dq_oe_cnt = 0; dq_changes = 0;
    oe_addr = '0; we_addr = '0; rf_data = '0; dq_first = '0;
    for (int i = 0; i < 32; i++) busy_at[i] = 1'bx;
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      if (i < 32) busy_at[i] = busy;
      if (read_finish) begin
        rf_cnt++;
        if (rf_cyc < 0) rf_cyc = i;
        rf_data = rd_data;
      end
      if (write_finish) begin
        wf_cnt++;
        if (wf_cyc < 0) wf_cyc = i;
      end
      if (!sram_ce_n && !sram_oe_n) begin oe_low++; oe_addr = sram_addr; end
      if (!sram_ce_n && !sram_we_n) begin we_low++; we_addr = sram_addr; end
      if (sram_dq_oe && !sram_oe_n) contention++;
      if (sram_dq_oe) begin
        if (dq_oe_cnt == 0) dq_first = sram_dq_out;
        else if (sram_dq_out !== dq_first) dq_changes++;
        dq_oe_cnt++;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests++; if ({sram_ce_n, sram_oe_n, sram_we_n} !== 3'b111) begin fails++; $display("FAIL reset_strobes got %b want 111", {sram_ce_n, sram_oe_n, sram_we_n}); end
    tests++; if ({sram_ub_n, sram_lb_n} !== 2'b00) begin fails++; $display("FAIL reset_ub_lb got %b want 00", {sram_ub_n, sram_lb_n}); end
    tests++; if ({sram_dq_oe, read_finish, write_finish, busy} !== 4'b0000) begin fails++; $display("FAIL reset_flags got %b want 0000", {sram_dq_oe, read_finish, write_finish, busy}); end
    tests++; if (sram_addr !== 18'h0 || sram_dq_out !== 16'h0 || rd_data !== 16'h0) begin fails++; $display("FAIL reset_values addr %h dq %h rd %h want 0", sram_addr, sram_dq_out, rd_data); end
    @(posedge clk); #1;
    rst = 1'b0;
    model_head = '0;
    rd_q.delete(); wr_q.delete();
  endtask

  task automatic test_read;
    exp_t e;
    preload(exp_addr(model_head, 12'd2048), 16'h1234);
    issue(1'b1, 1'b0, 12'd2048, 16'h0);
    watch(6);
    e = rd_q.pop_front();
    tests++; if (oe_addr !== e.addr) begin fails++; $display("FAIL read_addr got %h want %h", oe_addr, e.addr); end
    tests++; if (oe_low != 2) begin fails++; $display("FAIL read_oe_cycles got %0d want 2", oe_low); end
    tests++; if (rf_cyc != 3 || rf_cnt != 1) begin fails++; $display("FAIL read_finish_timing got cyc %0d cnt %0d want 3/1", rf_cyc, rf_cnt); end
    tests++; if (rf_data !== e.data) begin fails++; $display("FAIL read_data got %h want %h", rf_data, e.data); end
    tests++; if (contention != 0) begin fails++; $display("FAIL read_contention got %0d want 0", contention); end
  endtask

  task automatic test_write;
    exp_t e;
    ticks(5);
    issue(1'b0, 1'b1, 12'd1, 16'hBEEF);
    watch(8);
    e = wr_q.pop_front();
    tests++; if (we_addr !== e.addr || e.addr !== BASE + 18'd4) begin fails++; $display("FAIL write_addr got %h want %h", we_addr, BASE + 18'd4); end
    tests++; if (we_low != 2) begin fails++; $display("FAIL write_we_cycles got %0d want 2", we_low); end
    tests++; if (dq_oe_cnt != 4 || dq_changes != 0 || dq_first !== e.data) begin fails++; $display("FAIL write_dq_stable got oe %0d chg %0d val %h want 4/0/%h", dq_oe_cnt, dq_changes, dq_first, e.data); end
    tests++; if (wf_cyc != 5 || wf_cnt != 1) begin fails++; $display("FAIL write_finish_timing got cyc %0d cnt %0d want 5/1", wf_cyc, wf_cnt); end
    tests++; if (mem[e.addr] !== e.data) begin fails++; $display("FAIL write_mem got %h want %h", mem[e.addr], e.data); end
  endtask

  task automatic test_back_to_back;
    exp_t er, ew;
    preload(exp_addr(model_head, 12'd2048), 16'h5A5A);
    issue(1'b1, 1'b1, 12'd2048, 16'hC0DE);
    watch(12);
    er = rd_q.pop_front();
    ew = wr_q.pop_front();
    tests++; if (rf_cyc != 3 || rf_cnt != 1) begin fails++; $display("FAIL b2b_read_finish got cyc %0d cnt %0d want 3/1", rf_cyc, rf_cnt); end
    tests++; if (wf_cyc != 9 || wf_cnt != 1) begin fails++; $display("FAIL b2b_write_finish got cyc %0d cnt %0d want 9/1", wf_cyc, wf_cnt); end
    tests++; if (rf_data !== er.data) begin fails++; $display("FAIL b2b_read_data got %h want %h", rf_data, er.data); end
    tests++; if (busy_at[4] !== 1'b1) begin fails++; $display("FAIL b2b_busy_idle got %b want 1", busy_at[4]); end
    tests++; if (oe_addr !== er.addr || we_addr !== ew.addr) begin fails++; $display("FAIL b2b_addr got %h/%h want %h/%h", oe_addr, we_addr, er.addr, ew.addr); end
    tests++; if (mem[ew.addr] !== ew.data) begin fails++; $display("FAIL b2b_mem got %h want %h", mem[ew.addr], ew.data); end
    tests++; if (busy_at[10] !== 1'b0) begin fails++; $display("FAIL b2b_busy_end got %b want 0", busy_at[10]); end
  endtask

  task automatic test_wrap;
    exp_t e;
    test_reset();
    ticks(4096);
    preload(BASE + 18'd4095, 16'h0FF0);
    issue(1'b1, 1'b0, 12'd1, 16'h0);
    watch(6);
    e = rd_q.pop_front();
    tests++; if (oe_addr !== BASE + 18'd4095 || e.addr !== BASE + 18'd4095) begin fails++; $display("FAIL wrap_addr got %h want %h", oe_addr, BASE + 18'd4095); end
    tests++; if (rf_data !== 16'h0FF0) begin fails++; $display("FAIL wrap_data got %h want 0ff0", rf_data); end
  endtask

  task automatic test_reset_mid_write;
    preload(exp_addr(model_head, 12'd0), 16'h1111);
    issue(1'b0, 1'b1, 12'd0, 16'h7777);
    void'(wr_q.pop_front());
    @(negedge clk);
    @(negedge clk);
    tests++; if (sram_we_n !== 1'b0) begin fails++; $display("FAIL rmw_in_pulse got we_n %b want 0", sram_we_n); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_head = '0;
    @(negedge clk);
    tests++; if ({sram_ce_n, sram_we_n, sram_dq_oe, write_finish, busy} !== 5'b11000) begin fails++; $display("FAIL rmw_abort got %b want 11000", {sram_ce_n, sram_we_n, sram_dq_oe, write_finish, busy}); end
    watch(8);
    tests++; if (wf_cnt != 0 || we_low != 0 || busy_at[8] !== 1'b0) begin fails++; $display("FAIL rmw_quiet got wf %0d we %0d busy %b want 0/0/0", wf_cnt, we_low, busy_at[8]); end
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_back_to_back();
    test_wrap();
    test_reset_mid_write();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/smart_ram.md
Name: smart_ram

Overview:
- Responder side of the effects-to-SRAM "smart_ram" interface.
- Accepts single-cycle read/write pulses from an effect block, each carrying an offset relative to a circular-buffer head pointer.
- Drives the external asynchronous 16-bit SRAM with programmable wait states and returns one-cycle read_finish/write_finish pulses.
- Sits between the effect chain (echo, delay, etc.) and the board SRAM pins; head pointer advances once per audio sample.

Parameters:
- DATA_WIDTH, 16: sample/SRAM word width.
- ADDR_WIDTH, 12: offset and head-pointer width; buffer depth is 2^ADDR_WIDTH words.
- SRAM_ADDR_WIDTH, 18: external SRAM address width.
- BASE_ADDR, 0: physical SRAM base of the buffer.
- READ_WAIT, 2: cycles oe_n is held low per read, minimum 1.
- WRITE_WAIT, 2: cycles we_n is held low per write, minimum 1.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- sample_tick  in  1  advance head pointer by one
- req_rd  in  1  read request pulse
- req_wr  in  1  write request pulse
- req_offset  in  ADDR_WIDTH  offset behind head, sampled with req_rd/req_wr
- req_data  in  DATA_WIDTH  write data, sampled with req_wr
- rd_data  out  DATA_WIDTH  last read word, held until next read completes
- read_finish  out  1  one-cycle read completion pulse
- write_finish  out  1  one-cycle write completion pulse
- busy  out  1  high whenever FSM is not IDLE or a request is pending
- sram_addr  out  SRAM_ADDR_WIDTH  SRAM address
- sram_dq_out  out  DATA_WIDTH  SRAM write data
- sram_dq_oe  out  1  tri-state enable for sram_dq_out (top level builds the inout)
- sram_dq_in  in  DATA_WIDTH  SRAM read data
- sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n  out  1 each  SRAM strobes, active low

Behaviour:
- Reset values:
  - All strobes high except ub_n/lb_n, which are held 0.
  - sram_dq_oe=0, sram_addr=0, sram_dq_out=0, rd_data=0.
  - read_finish=0, write_finish=0.
  - head=0, pending flags cleared, state=IDLE.
- Reset mid-operation aborts the access immediately: strobes return high the cycle after rst is sampled, and no finish pulse is emitted.
- Request capture (any state):
  - req_rd sets pend_rd and latches rd_addr = BASE_ADDR + ((head - req_offset) mod 2^ADDR_WIDTH).
  - req_wr sets pend_wr and latches wr_addr the same way, plus wr_data = req_data.
  - A request arriving while the same pending flag is already set overwrites address/data (last wins).
- Head pointer: sample_tick increments head, wrapping 2^ADDR_WIDTH-1 to 0. Addresses computed in the same cycle use the pre-increment head.
- FSM states: IDLE, RD, RD_DONE, W_SETUP, W_PULSE, W_HOLD, WR_DONE.
  - IDLE: pend_rd goes to RD, otherwise pend_wr goes to W_SETUP. If both are pending, read is served first. A request pulse in IDLE is launched in the same cycle it is sampled (combinational bypass into the launch path).
  - RD: ce_n=0, oe_n=0, addr=rd_addr, held for READ_WAIT cycles. sram_dq_in is captured into rd_data at the end of the last RD cycle.
  - RD_DONE: read_finish=1, clear pend_rd, then go to IDLE.
  - W_SETUP (1 cycle): addr/dq driven, dq_oe=1, ce_n=0, we_n=1.
  - W_PULSE (WRITE_WAIT cycles): we_n=0.
  - W_HOLD (1 cycle): we_n=1, data still driven.
  - WR_DONE: write_finish=1, dq_oe=0, clear pend_wr, then go to IDLE.
- Latency, with the request sampled at edge k:
  - read_finish is high in cycle k+READ_WAIT+1.
  - write_finish is high in cycle k+WRITE_WAIT+3.
  - A queued write after a read adds 1 IDLE cycle.
- sram_dq_oe and oe_n are never low/high together in the same cycle; this prevents bus contention.
- A request pulse landing in a *_DONE cycle is latched and serviced after the IDLE pass.

Decomposition:
- Package smart_ram_pkg holds:
  - state encoding localparams (3 bits);
  - default READ_WAIT/WRITE_WAIT;
  - the ADDR_WIDTH/DATA_WIDTH defaults shared with effect modules.
- Sub-module smart_ram_addr_gen holds the head counter with wrap, the offset subtract and the BASE_ADDR add. It is combinational address output plus a registered head.

Test Plan:
- Reset: rst high 2 cycles -> all strobes 1, dq_oe 0, finishes 0, busy 0, head 0.
- Read: head=0, req_rd with offset 2048, SRAM model returns 0x1234 -> addr BASE+2048, oe_n low 2 cycles, read_finish 3 cycles after request, rd_data=0x1234.
- Write: 5 sample_ticks, then req_wr with offset 1, data 0xBEEF -> addr BASE+4, we_n low exactly 2 cycles, data stable setup through hold, write_finish 5 cycles after, model holds 0xBEEF.
- Simultaneous req_rd and req_wr, offset 2048 -> read completes first, then one IDLE cycle, then the write to the same address; two separate finish pulses.
- Wrap: 4096 sample_ticks return head to 0; then req_rd with offset 1 at head=0 -> addr BASE+4095.
- Reset mid-write, asserted during W_PULSE -> we_n high next cycle, no write_finish, FSM IDLE, pending cleared.
